// File: rtl/zpc_pkg.sv
// ============================================================================
// Module  : zpc_pkg
// Brief   : Shared constants and types for the video-memory write path:
//           video-region address tag, default widths, drain FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package zpc_pkg;

  // CPU addresses whose top nibble equals this tag target video memory
  localparam logic [3:0] VIDEO_TAG = 4'hA;

  // Default widths for the video-memory write port
  localparam int VMWB_VADDR_W = 28;
  localparam int VMWB_DATA_W  = 32;

  // Drain FSM state encoding
  typedef logic [0:0] vmwb_state_t;
  localparam vmwb_state_t ST_IDLE  = 1'b0;
  localparam vmwb_state_t ST_WRITE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/vm_write_buffer_if.sv
// ============================================================================
// Module  : vm_write_buffer_if
// Brief   : CPU-side write bus and video-memory write port of the write
//           buffer. master = CPU/system side, slave = the buffer itself.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface vm_write_buffer_if import zpc_pkg::*; #(
  parameter int DEPTH   = 8,
  parameter int VADDR_W = VMWB_VADDR_W,
  parameter int DATA_W  = VMWB_DATA_W
);

  // CPU side
  logic [31:0]             cpu_addr;
  logic [DATA_W-1:0]       cpu_data;
  logic                    cpu_we;
  logic                    blank;

  // Video-memory side and status
  logic                    vm_we;
  logic [VADDR_W-1:0]      vm_addr;
  logic [DATA_W-1:0]       vm_data;
  logic                    full;
  logic                    empty;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;

  modport master (
    output cpu_addr, cpu_data, cpu_we, blank,
    input  vm_we, vm_addr, vm_data, full, empty, level, overflow
  );

  modport slave (
    input  cpu_addr, cpu_data, cpu_we, blank,
    output vm_we, vm_addr, vm_data, full, empty, level, overflow
  );

endinterface

`default_nettype wire

// File: rtl/vmwb_fifo.sv
// ============================================================================
// Module  : vmwb_fifo
// Brief   : Synchronous FIFO, power-of-two depth. A push while full is only
//           accepted if a pop happens in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vmwb_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 60
) (
  input  wire logic                   clk_50mhz,
  input  wire logic                   rst,
  input  wire logic                   push,
  input  wire logic                   pop,
  input  wire logic [WIDTH-1:0]       wdata,
  output logic      [WIDTH-1:0]       rdata,
  output logic      [$clog2(DEPTH):0] level,
  output logic                        full,
  output logic                        empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH; level tracks net push/pop
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents need no reset since level gates validity
  always_ff @(posedge clk_50mhz) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/vm_write_buffer.sv
// ============================================================================
// Module  : vm_write_buffer
// Brief   : Captures CPU word writes to the video region (one per strobe
//           rising edge), queues them, and drains them to video memory as
//           single-cycle write pulses, at most one every two cycles.
//           Build option VMWB_BLANK_ONLY_EN: when defined, a new video write
//           is started only while blank=1 (an already started one completes).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vm_write_buffer import zpc_pkg::*; #(
  parameter int DEPTH   = 8,
  parameter int VADDR_W = VMWB_VADDR_W,
  parameter int DATA_W  = VMWB_DATA_W
) (
  input wire logic          clk_50mhz,
  input wire logic          rst,
  vm_write_buffer_if.slave  bus
);

  localparam int WIDTH = VADDR_W + DATA_W;

  vmwb_state_t      state;
  logic             we_q;
  logic             push_ev;
  logic             drain_ok;
  logic             go;
  logic             pop;
  logic [WIDTH-1:0] head;

  // Rising edge of the strobe into the video region is one push
  assign push_ev = bus.cpu_we & ~we_q & (bus.cpu_addr[31:28] == VIDEO_TAG);

`ifdef VMWB_BLANK_ONLY_EN
  assign drain_ok = bus.blank;
`else
  // blank has no effect in this build
  assign drain_ok = bus.blank | 1'b1;
`endif

  assign go  = (state == ST_IDLE) & ~bus.empty & drain_ok;
  assign pop = (state == ST_WRITE);

  vmwb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .push      (push_ev),
    .pop       (pop),
    .wdata     ({bus.cpu_addr[VADDR_W-1:0], bus.cpu_data}),
    .rdata     (head),
    .level     (bus.level),
    .full      (bus.full),
    .empty     (bus.empty)
  );

  // Strobe history for edge detection
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) we_q <= 1'b0;
    else     we_q <= bus.cpu_we;
  end

  // Drain FSM: WRITE lasts one cycle and always returns to IDLE
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state <= go ? ST_WRITE : ST_IDLE;
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Output port is loaded on entry to WRITE so it is valid during WRITE
  // and holds the last written entry afterwards
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      bus.vm_we   <= 1'b0;
      bus.vm_addr <= '0;
      bus.vm_data <= '0;
    end else begin
      bus.vm_we <= go;
      if (go) begin
        bus.vm_addr <= head[WIDTH-1:DATA_W];
        bus.vm_data <= head[DATA_W-1:0];
      end
    end
  end

  // A push that finds the FIFO full with no pop is lost; remember it
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst)                               bus.overflow <= 1'b0;
    else if (push_ev & bus.full & ~pop)    bus.overflow <= 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_vm_write_buffer.sv
// ============================================================================
// Module  : tb_vm_write_buffer
// Brief   : Directed self-checking bench for vm_write_buffer. Tests that
//           depend on holding off the drain are built only when
//           VMWB_BLANK_ONLY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vm_write_buffer;
  import zpc_pkg::*;

  localparam int DEPTH   = 8;
  localparam int VADDR_W = 28;
  localparam int DATA_W  = 32;

  logic clk_50mhz = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [VADDR_W-1:0] mon_addr[$];
  logic [DATA_W-1:0]  mon_data[$];
  int                 mon_cyc[$];

  always #10 clk_50mhz = ~clk_50mhz;

  always @(posedge clk_50mhz) cyc <= cyc + 1;

  vm_write_buffer_if #(.DEPTH(DEPTH), .VADDR_W(VADDR_W), .DATA_W(DATA_W)) bus ();

  vm_write_buffer #(.DEPTH(DEPTH), .VADDR_W(VADDR_W), .DATA_W(DATA_W)) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .bus       (bus)
  );

  // Record every video-memory write pulse with the cycle it appeared in
  always @(negedge clk_50mhz) begin
    if (bus.vm_we === 1'b1) begin
      mon_addr.push_back(bus.vm_addr);
      mon_data.push_back(bus.vm_data);
      mon_cyc.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50mhz);
      #1;
    end
  endtask

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    mon_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    clear_mon();
    tick(1);
  endtask

  // Strobe cpu_we for hi cycles then one low cycle; ev is the push-event cycle
  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input int hi, output int ev);
    bus.cpu_addr = a;
    bus.cpu_data = d;
    bus.cpu_we   = 1'b1;
    ev           = cyc;
    tick(hi);
    bus.cpu_we   = 1'b0;
    tick(1);
  endtask

  function automatic logic [63:0] q_data(input int i);
    return (mon_data.size() > i) ? 64'(mon_data[i]) : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [63:0] q_addr(input int i);
    return (mon_addr.size() > i) ? 64'(mon_addr[i]) : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  initial begin
    int ev;
    int seen;
    rst          = 1'b1;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;
    bus.cpu_we   = 1'b0;
    bus.blank    = 1'b1;
    tick(2);

    // Reset state, observed while rst is still high
    check_val("rst_empty",    bus.empty,    1);
    check_val("rst_full",     bus.full,     0);
    check_val("rst_level",    bus.level,    0);
    check_val("rst_overflow", bus.overflow, 0);
    check_val("rst_vm_we",    bus.vm_we,    0);
    check_val("rst_vm_addr",  bus.vm_addr,  0);
    check_val("rst_vm_data",  bus.vm_data,  0);
    rst = 1'b0;
    clear_mon();
    tick(1);

    // Single write with an 8-cycle strobe
    cpu_write(32'hA000_0010, 32'h00FF_00AA, 8, ev);
    tick(10);
    check_val("single_count",   mon_data.size(), 1);
    check_val("single_addr",    q_addr(0), 64'h000_0010);
    check_val("single_data",    q_data(0), 64'h00FF_00AA);
    check_val("single_latency", (mon_cyc.size() > 0) ? mon_cyc[0] - ev : -1, 2);
    check_val("hold_addr",      bus.vm_addr, 28'h000_0010);
    check_val("hold_data",      bus.vm_data, 32'h00FF_00AA);

    // Non-video address is filtered out
    clear_mon();
    cpu_write(32'h0000_0010, 32'h1234_5678, 3, ev);
    tick(6);
    check_val("filter_level", bus.level, 0);
    check_val("filter_empty", bus.empty, 1);
    check_val("filter_count", mon_data.size(), 0);

`ifdef VMWB_BLANK_ONLY_EN
    // Overflow: nine writes with drain held off
    do_reset();
    bus.blank = 1'b0;
    for (int i = 1; i <= 9; i++) cpu_write(32'hA000_0000 + 32'(i * 4), 32'(i), 1, ev);
    check_val("ovf_level",    bus.level,    8);
    check_val("ovf_full",     bus.full,     1);
    check_val("ovf_overflow", bus.overflow, 1);
    check_val("ovf_no_drain", mon_data.size(), 0);
    bus.blank = 1'b1;
    tick(25);
    check_val("ovf_drain_count", mon_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("ovf_data%0d", i), q_data(i), 64'(i + 1));
      check_val($sformatf("ovf_addr%0d", i), q_addr(i), 64'((i + 1) * 4));
    end
    check_val("ovf_empty",  bus.empty,    1);
    check_val("ovf_sticky", bus.overflow, 1);
    check_val("ovf_hold",   bus.vm_addr,  28'h20);

    // Push coinciding with a pop while full; blank drops in the WRITE cycle
    do_reset();
    bus.blank = 1'b0;
    for (int i = 0; i < 8; i++) cpu_write(32'hA000_0100 + 32'(i * 4), 32'h100 + 32'(i), 1, ev);
    check_val("pp_full_before", bus.full, 1);
    bus.blank = 1'b1;
    tick(1);
    bus.blank = 1'b0;
    cpu_write(32'hA000_01FC, 32'h1FF, 1, ev);
    check_val("pp_level",    bus.level,    8);
    check_val("pp_full",     bus.full,     1);
    check_val("pp_overflow", bus.overflow, 0);
    check_val("pp_one_wr",   mon_data.size(), 1);
    check_val("pp_first",    q_data(0), 64'h100);
    bus.blank = 1'b1;
    tick(25);
    check_val("pp_count", mon_data.size(), 9);
    check_val("pp_last",  q_data(8), 64'h1FF);
`endif

    // Reset asserted during a WRITE cycle
    do_reset();
`ifdef VMWB_BLANK_ONLY_EN
    bus.blank = 1'b0;
    for (int i = 0; i < 4; i++) cpu_write(32'hA000_0200 + 32'(i * 4), 32'h200 + 32'(i), 1, ev);
    check_val("rmd_level4", bus.level, 4);
    bus.blank = 1'b1;
`else
    for (int i = 0; i < 4; i++) cpu_write(32'hA000_0200 + 32'(i * 4), 32'h200 + 32'(i), 1, ev);
`endif
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_50mhz);
      if (bus.vm_we === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check_val("rmd_write_seen", seen, 1);
    rst = 1'b1;
    #1;
    clear_mon();
    check_val("rmd_vm_we",   bus.vm_we,   0);
    check_val("rmd_level",   bus.level,   0);
    check_val("rmd_empty",   bus.empty,   1);
    check_val("rmd_vm_data", bus.vm_data, 0);
    tick(2);
    rst = 1'b0;
    tick(20);
    check_val("rmd_no_more", mon_data.size(), 0);
    check_val("rmd_level_after", bus.level, 0);

    // Twenty writes interleaved with drains, pointers wrap
    do_reset();
    bus.blank = 1'b1;
    for (int i = 0; i < 20; i++)
      cpu_write(32'hA000_1000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1 + (i % 3), ev);
    tick(30);
    check_val("wrap_count", mon_data.size(), 20);
    for (int i = 0; i < 20; i++) begin
      check_val($sformatf("wrap_data%0d", i), q_data(i), 64'(32'hC0DE_0000 + 32'(i)));
      check_val($sformatf("wrap_addr%0d", i), q_addr(i), 64'(28'h000_1000 + 28'(i * 4)));
    end
    check_val("wrap_empty",    bus.empty,    1);
    check_val("wrap_overflow", bus.overflow, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
